axi_xbar_arbiter: RTL and testbench

- Shares the single AXI4 master port between the IFU, which issues instruction reads only, and the LSU, which issues data reads and writes.
- Sits between the core fetch/load-store units and the SoC-facing io_master_* interface.
- Serialises traffic: exactly one outstanding transaction at a time.
- Fair round-robin on contention, response routing by owner, and a response watchdog.

---
 rtl/axi_xbar_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_xbar_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_xbar_arbiter.sv
`default_nettype none
// =============================================================================
// axi_xbar_arbiter: round-robin IFU/LSU arbiter onto one AXI4 master port with
// a single transaction in flight, owner-routed responses and a response watchdog.
// Revision: 1.0
// =============================================================================
module axi_xbar_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    // IFU read port
    input  logic        ifu_arvalid_i,
    output logic        ifu_arready_o,
    input  logic [31:0] ifu_araddr_i,
    output logic        ifu_rvalid_o,
    input  logic        ifu_rready_i,
    output logic [31:0] ifu_rdata_o,
    output logic [1:0]  ifu_rresp_o,
    // LSU read port
    input  logic        lsu_arvalid_i,
    output logic        lsu_arready_o,
    input  logic [31:0] lsu_araddr_i,
    input  logic [2:0]  lsu_arsize_i,
    output logic        lsu_rvalid_o,
    input  logic        lsu_rready_i,
    output logic [31:0] lsu_rdata_o,
    output logic [1:0]  lsu_rresp_o,
    // LSU write port
    input  logic        lsu_awvalid_i,
    output logic        lsu_awready_o,
    input  logic [31:0] lsu_awaddr_i,
    input  logic [2:0]  lsu_awsize_i,
    input  logic        lsu_wvalid_i,
    output logic        lsu_wready_o,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  lsu_wstrb_i,
    output logic        lsu_bvalid_o,
    input  logic        lsu_bready_i,
    output logic [1:0]  lsu_bresp_o,
    // Downstream AXI4 master
    output logic        io_master_arvalid_o,
    output logic [31:0] io_master_araddr_o,
    output logic [3:0]  io_master_arid_o,
    output logic [7:0]  io_master_arlen_o,
    output logic [2:0]  io_master_arsize_o,
    output logic [1:0]  io_master_arburst_o,
    input  logic        io_master_arready_i,
    input  logic        io_master_rvalid_i,
    input  logic [31:0] io_master_rdata_i,
    input  logic [1:0]  io_master_rresp_i,
    input  logic        io_master_rlast_i,
    input  logic [3:0]  io_master_rid_i,
    output logic        io_master_rready_o,
    output logic        io_master_awvalid_o,
    output logic [31:0] io_master_awaddr_o,
    output logic [3:0]  io_master_awid_o,
    output logic [7:0]  io_master_awlen_o,
    output logic [2:0]  io_master_awsize_o,
    output logic [1:0]  io_master_awburst_o,
    input  logic        io_master_awready_i,
    output logic        io_master_wvalid_o,
    output logic [31:0] io_master_wdata_o,
    output logic [3:0]  io_master_wstrb_o,
    output logic        io_master_wlast_o,
    input  logic        io_master_wready_i,
    input  logic        io_master_bvalid_i,
    input  logic [1:0]  io_master_bresp_i,
    input  logic [3:0]  io_master_bid_i,
    output logic        io_master_bready_o,
    output logic        err_timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IFU_AR = 3'd1,
        S_IFU_R  = 3'd2,
        S_LSU_AR = 3'd3,
        S_LSU_R  = 3'd4,
        S_LSU_WR = 3'd5,
        S_LSU_B  = 3'd6
    } state_e;

    localparam logic             GRANT_IFU = 1'b0;
    localparam logic             GRANT_LSU = 1'b1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             err_q, err_d;

    logic req_ifu, req_lsu, lsu_wr_req, resp_hs, wait_state;

    // Routing is purely by state, so the response IDs carry no information here.
    logic unused_ids;
    assign unused_ids = ^{io_master_rid_i, io_master_bid_i};

    assign req_ifu    = ifu_arvalid_i;
    assign lsu_wr_req = lsu_awvalid_i & lsu_wvalid_i;
    assign req_lsu    = lsu_arvalid_i | lsu_wr_req;

    assign ifu_rdata_o = io_master_rdata_i;
    assign ifu_rresp_o = io_master_rresp_i;
    assign lsu_rdata_o = io_master_rdata_i;
    assign lsu_rresp_o = io_master_rresp_i;
    assign lsu_bresp_o = io_master_bresp_i;

    assign io_master_arlen_o   = 8'd0;
    assign io_master_arburst_o = 2'b01;
    assign io_master_awaddr_o  = lsu_awaddr_i;
    assign io_master_awid_o    = 4'd1;
    assign io_master_awlen_o   = 8'd0;
    assign io_master_awsize_o  = lsu_awsize_i;
    assign io_master_awburst_o = 2'b01;
    assign io_master_wdata_o   = lsu_wdata_i;
    assign io_master_wstrb_o   = lsu_wstrb_i;
    assign err_timeout_o       = err_q;

    always_comb begin
        state_d             = state_q;
        last_grant_d        = last_grant_q;
        aw_done_d           = aw_done_q;
        w_done_d            = w_done_q;
        resp_hs             = 1'b0;
        ifu_arready_o       = 1'b0;
        ifu_rvalid_o        = 1'b0;
        lsu_arready_o       = 1'b0;
        lsu_rvalid_o        = 1'b0;
        lsu_awready_o       = 1'b0;
        lsu_wready_o        = 1'b0;
        lsu_bvalid_o        = 1'b0;
        io_master_arvalid_o = 1'b0;
        io_master_araddr_o  = ifu_araddr_i;
        io_master_arid_o    = 4'd0;
        io_master_arsize_o  = 3'b010;
        io_master_rready_o  = 1'b0;
        io_master_awvalid_o = 1'b0;
        io_master_wvalid_o  = 1'b0;
        io_master_wlast_o   = 1'b0;
        io_master_bready_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_ifu && (!req_lsu || last_grant_q == GRANT_LSU)) begin
                    state_d      = S_IFU_AR;
                    last_grant_d = GRANT_IFU;
                end else if (req_lsu) begin
                    // A pending store goes ahead of a pending load to keep RAW order.
                    state_d      = lsu_wr_req ? S_LSU_WR : S_LSU_AR;
                    last_grant_d = GRANT_LSU;
                end
            end
            S_IFU_AR: begin
                io_master_arvalid_o = 1'b1;
                ifu_arready_o       = io_master_arready_i;
                if (io_master_arready_i) state_d = S_IFU_R;
            end
            S_LSU_AR: begin
                io_master_arvalid_o = 1'b1;
                io_master_araddr_o  = lsu_araddr_i;
                io_master_arsize_o  = lsu_arsize_i;
                io_master_arid_o    = 4'd1;
                lsu_arready_o       = io_master_arready_i;
                if (io_master_arready_i) state_d = S_LSU_R;
            end
            S_IFU_R: begin
                io_master_rready_o = ifu_rready_i;
                ifu_rvalid_o       = io_master_rvalid_i;
                resp_hs            = io_master_rvalid_i & ifu_rready_i;
                if (resp_hs && io_master_rlast_i) state_d = S_IDLE;
            end
            S_LSU_R: begin
                io_master_rready_o = lsu_rready_i;
                lsu_rvalid_o       = io_master_rvalid_i;
                resp_hs            = io_master_rvalid_i & lsu_rready_i;
                if (resp_hs && io_master_rlast_i) state_d = S_IDLE;
            end
            S_LSU_WR: begin
                io_master_awvalid_o = !aw_done_q;
                io_master_wvalid_o  = !w_done_q;
                io_master_wlast_o   = !w_done_q;
                lsu_awready_o       = io_master_awready_i & !aw_done_q;
                lsu_wready_o        = io_master_wready_i & !w_done_q;
                aw_done_d           = aw_done_q | io_master_awready_i;
                w_done_d            = w_done_q | io_master_wready_i;
                if (aw_done_d && w_done_d) state_d = S_LSU_B;
            end
            S_LSU_B: begin
                io_master_bready_o = lsu_bready_i;
                lsu_bvalid_o       = io_master_bvalid_i;
                resp_hs            = io_master_bvalid_i & lsu_bready_i;
                if (resp_hs) begin
                    state_d   = S_IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Watchdog counts stalled response cycles and saturates; the flag is sticky.
    assign wait_state = (state_q == S_IFU_R) || (state_q == S_LSU_R) || (state_q == S_LSU_B);

    always_comb begin
        wdog_d = '0;
        err_d  = err_q;
        if (wait_state && !resp_hs && state_d == state_q) begin
            wdog_d = (wdog_q == TIMEOUT_C) ? wdog_q : wdog_q + 1'b1;
            if (wdog_d == TIMEOUT_C) err_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_LSU;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            wdog_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            wdog_q       <= wdog_d;
            err_q        <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_xbar_arbiter.sv
`default_nettype none
// Directed testbench for axi_xbar_arbiter; the bench plays both upstream units
// and the downstream slave, checking outputs on the falling clock edge.
module tb_axi_xbar_arbiter;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    logic        clock, reset_n;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [2:0]  lsu_arsize, lsu_awsize;
    logic [1:0]  lsu_rresp, lsu_bresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        io_arvalid, io_arready, io_rvalid, io_rlast, io_rready;
    logic [31:0] io_araddr, io_rdata, io_awaddr, io_wdata;
    logic [3:0]  io_arid, io_rid, io_awid, io_wstrb, io_bid;
    logic [7:0]  io_arlen, io_awlen;
    logic [2:0]  io_arsize, io_awsize;
    logic [1:0]  io_arburst, io_rresp, io_awburst, io_bresp;
    logic        io_awvalid, io_awready, io_wvalid, io_wlast, io_wready;
    logic        io_bvalid, io_bready, err_timeout;

    int total = 0;
    int passed = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt = 0;

    axi_xbar_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock_i(clock), .reset_ni(reset_n),
        .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(ifu_arready), .ifu_araddr_i(ifu_araddr),
        .ifu_rvalid_o(ifu_rvalid), .ifu_rready_i(ifu_rready), .ifu_rdata_o(ifu_rdata), .ifu_rresp_o(ifu_rresp),
        .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(lsu_arready), .lsu_araddr_i(lsu_araddr), .lsu_arsize_i(lsu_arsize),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rready_i(lsu_rready), .lsu_rdata_o(lsu_rdata), .lsu_rresp_o(lsu_rresp),
        .lsu_awvalid_i(lsu_awvalid), .lsu_awready_o(lsu_awready), .lsu_awaddr_i(lsu_awaddr), .lsu_awsize_i(lsu_awsize),
        .lsu_wvalid_i(lsu_wvalid), .lsu_wready_o(lsu_wready), .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb),
        .lsu_bvalid_o(lsu_bvalid), .lsu_bready_i(lsu_bready), .lsu_bresp_o(lsu_bresp),
        .io_master_arvalid_o(io_arvalid), .io_master_araddr_o(io_araddr), .io_master_arid_o(io_arid),
        .io_master_arlen_o(io_arlen), .io_master_arsize_o(io_arsize), .io_master_arburst_o(io_arburst),
        .io_master_arready_i(io_arready),
        .io_master_rvalid_i(io_rvalid), .io_master_rdata_i(io_rdata), .io_master_rresp_i(io_rresp),
        .io_master_rlast_i(io_rlast), .io_master_rid_i(io_rid), .io_master_rready_o(io_rready),
        .io_master_awvalid_o(io_awvalid), .io_master_awaddr_o(io_awaddr), .io_master_awid_o(io_awid),
        .io_master_awlen_o(io_awlen), .io_master_awsize_o(io_awsize), .io_master_awburst_o(io_awburst),
        .io_master_awready_i(io_awready),
        .io_master_wvalid_o(io_wvalid), .io_master_wdata_o(io_wdata), .io_master_wstrb_o(io_wstrb),
        .io_master_wlast_o(io_wlast), .io_master_wready_i(io_wready),
        .io_master_bvalid_i(io_bvalid), .io_master_bresp_i(io_bresp), .io_master_bid_i(io_bid),
        .io_master_bready_o(io_bready), .err_timeout_o(err_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count downstream AW/W handshakes just before each rising edge.
    always begin
        @(negedge clock);
        #4;
        if (io_awvalid && io_awready) aw_hs_cnt++;
        if (io_wvalid && io_wready) w_hs_cnt++;
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (io_arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b want 0", io_arvalid); else passed++;
        total++; if (io_awvalid !== 1'b0 || io_wvalid !== 1'b0) $display("FAIL rst_aw_w_valid: got %b%b want 00", io_awvalid, io_wvalid); else passed++;
        total++; if (io_rready !== 1'b0 || io_bready !== 1'b0) $display("FAIL rst_r_b_ready: got %b%b want 00", io_rready, io_bready); else passed++;
        total++; if (ifu_arready !== 1'b0 || lsu_awready !== 1'b0) $display("FAIL rst_up_ready: got %b%b want 00", ifu_arready, lsu_awready); else passed++;
        total++; if (err_timeout !== 1'b0) $display("FAIL rst_err: got %b want 0", err_timeout); else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_tie_alternation();
        logic        exp_lsu;
        logic [31:0] exp_data;
        for (int i = 0; i < 4; i++) begin
            exp_lsu     = i[0];
            exp_data    = 32'hA5A5_0000 + 32'(i);
            ifu_arvalid = 1'b1; ifu_araddr = 32'h1000_0000 + 32'(i * 4);
            lsu_arvalid = 1'b1; lsu_araddr = 32'h2000_0000 + 32'(i * 4); lsu_arsize = 3'b001;
            io_arready  = 1'b1;
            #1;
            total++; if (io_arvalid !== 1'b0) $display("FAIL tie%0d_idle_arvalid: got %b want 0", i, io_arvalid); else passed++;
            @(negedge clock);
            total++; if (io_arvalid !== 1'b1) $display("FAIL tie%0d_arvalid: got %b want 1", i, io_arvalid); else passed++;
            total++; if (io_arid !== (exp_lsu ? 4'd1 : 4'd0)) $display("FAIL tie%0d_arid: got %0d want %0d", i, io_arid, exp_lsu); else passed++;
            total++; if (io_araddr !== ((exp_lsu ? 32'h2000_0000 : 32'h1000_0000) + 32'(i * 4))) $display("FAIL tie%0d_araddr: got %h", i, io_araddr); else passed++;
            total++; if (io_arsize !== (exp_lsu ? 3'b001 : 3'b010)) $display("FAIL tie%0d_arsize: got %b", i, io_arsize); else passed++;
            total++; if (io_arlen !== 8'd0 || io_arburst !== 2'b01) $display("FAIL tie%0d_len_burst: got %h/%b want 00/01", i, io_arlen, io_arburst); else passed++;
            total++; if (ifu_arready !== !exp_lsu || lsu_arready !== exp_lsu) $display("FAIL tie%0d_up_arready: got ifu %b lsu %b", i, ifu_arready, lsu_arready); else passed++;
            ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
            @(negedge clock);
            io_arready = 1'b0;
            io_rvalid = 1'b1; io_rlast = 1'b1; io_rdata = exp_data; io_rresp = 2'b00;
            ifu_rready = 1'b1; lsu_rready = 1'b1;
            #1;
            total++; if (io_arvalid !== 1'b0) $display("FAIL tie%0d_arvalid_drop: got %b want 0", i, io_arvalid); else passed++;
            total++; if (ifu_rvalid !== !exp_lsu || lsu_rvalid !== exp_lsu) $display("FAIL tie%0d_rvalid_route: got ifu %b lsu %b", i, ifu_rvalid, lsu_rvalid); else passed++;
            total++; if ((exp_lsu ? lsu_rdata : ifu_rdata) !== exp_data) $display("FAIL tie%0d_rdata: got %h want %h", i, exp_lsu ? lsu_rdata : ifu_rdata, exp_data); else passed++;
            @(negedge clock);
            io_rvalid = 1'b0; io_rlast = 1'b0; ifu_rready = 1'b0; lsu_rready = 1'b0;
        end
    endtask

    task automatic test_ifu_read();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; io_arready = 1'b0;
        @(negedge clock);
        total++; if (io_arvalid !== 1'b1 || io_araddr !== 32'h3000_0000) $display("FAIL ifu_ar: got %b %h want 1 30000000", io_arvalid, io_araddr); else passed++;
        total++; if (ifu_arready !== 1'b0) $display("FAIL ifu_arready_low: got %b want 0", ifu_arready); else passed++;
        io_arready = 1'b1;
        #1;
        total++; if (ifu_arready !== 1'b1) $display("FAIL ifu_arready_comb: got %b want 1", ifu_arready); else passed++;
        @(negedge clock);
        ifu_arvalid = 1'b0; io_arready = 1'b0;
        io_rvalid = 1'b1; io_rlast = 1'b1; io_rdata = 32'h0010_0093; io_rresp = 2'b01;
        ifu_rready = 1'b1; lsu_rready = 1'b0;
        #1;
        total++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0010_0093) $display("FAIL ifu_r: got %b %h want 1 00100093", ifu_rvalid, ifu_rdata); else passed++;
        total++; if (ifu_rresp !== 2'b01) $display("FAIL ifu_rresp: got %b want 01", ifu_rresp); else passed++;
        total++; if (lsu_rvalid !== 1'b0) $display("FAIL ifu_lsu_rvalid: got %b want 0", lsu_rvalid); else passed++;
        total++; if (io_rready !== 1'b1) $display("FAIL ifu_io_rready: got %b want 1", io_rready); else passed++;
        @(negedge clock);
        io_rvalid = 1'b0; io_rlast = 1'b0; ifu_rready = 1'b0;
        #1;
        total++; if (ifu_rvalid !== 1'b0 || io_rready !== 1'b0 || io_arvalid !== 1'b0) $display("FAIL ifu_back_idle: got rv %b rr %b av %b want 000", ifu_rvalid, io_rready, io_arvalid); else passed++;
    endtask

    task automatic test_write_split();
        int aw0, w0;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        io_awready = 1'b0; io_wready = 1'b0;
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h0F00_0004; lsu_awsize = 3'b010;
        lsu_wvalid = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        @(negedge clock);
        total++; if (io_awvalid !== 1'b1 || io_wvalid !== 1'b1 || io_wlast !== 1'b1) $display("FAIL wr_valids: got aw %b w %b last %b want 111", io_awvalid, io_wvalid, io_wlast); else passed++;
        total++; if (io_awaddr !== 32'h0F00_0004 || io_awid !== 4'd1 || io_awlen !== 8'd0) $display("FAIL wr_aw_fields: got %h id %0d len %0d", io_awaddr, io_awid, io_awlen); else passed++;
        total++; if (io_awsize !== 3'b010 || io_awburst !== 2'b01) $display("FAIL wr_aw_size_burst: got %b %b want 010 01", io_awsize, io_awburst); else passed++;
        total++; if (io_wdata !== 32'hDEAD_BEEF || io_wstrb !== 4'hF) $display("FAIL wr_w_fields: got %h %h want deadbeef f", io_wdata, io_wstrb); else passed++;
        io_awready = 1'b1;
        #1;
        total++; if (lsu_awready !== 1'b1 || lsu_wready !== 1'b0) $display("FAIL wr_up_ready1: got aw %b w %b want 10", lsu_awready, lsu_wready); else passed++;
        @(negedge clock);
        lsu_awvalid = 1'b0;
        repeat (2) begin
            #1;
            total++; if (io_awvalid !== 1'b0 || lsu_awready !== 1'b0 || io_wvalid !== 1'b1) $display("FAIL wr_aw_held_off: got awv %b awr %b wv %b want 001", io_awvalid, lsu_awready, io_wvalid); else passed++;
            @(negedge clock);
        end
        io_wready = 1'b1;
        #1;
        total++; if (lsu_wready !== 1'b1 || io_wvalid !== 1'b1) $display("FAIL wr_w_ready: got wr %b wv %b want 11", lsu_wready, io_wvalid); else passed++;
        @(negedge clock);
        lsu_wvalid = 1'b0; io_wready = 1'b0; io_awready = 1'b0;
        #1;
        total++; if (io_awvalid !== 1'b0 || io_wvalid !== 1'b0 || lsu_bvalid !== 1'b0) $display("FAIL wr_in_b_quiet: got %b%b%b want 000", io_awvalid, io_wvalid, lsu_bvalid); else passed++;
        total++; if (aw_hs_cnt - aw0 != 1 || w_hs_cnt - w0 != 1) $display("FAIL wr_hs_count: got aw %0d w %0d want 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0); else passed++;
        io_bvalid = 1'b1; io_bresp = 2'b00; lsu_bready = 1'b1;
        #1;
        total++; if (lsu_bvalid !== 1'b1 || lsu_bresp !== 2'b00 || io_bready !== 1'b1) $display("FAIL wr_b_route: got %b %b %b want 1 00 1", lsu_bvalid, lsu_bresp, io_bready); else passed++;
        @(negedge clock);
        io_bvalid = 1'b0; lsu_bready = 1'b0;
        #1;
        total++; if (io_bready !== 1'b0 || io_awvalid !== 1'b0) $display("FAIL wr_back_idle: got br %b awv %b want 00", io_bready, io_awvalid); else passed++;
    endtask

    task automatic test_write_same_cycle();
        int aw0, w0;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        io_awready = 1'b1; io_wready = 1'b1;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0F00_0004; lsu_arsize = 3'b010;
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h0F00_0008; lsu_wvalid = 1'b1;
        lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'h3;
        #1;
        total++; if (io_awvalid !== 1'b0) $display("FAIL same_idle_awvalid: got %b want 0", io_awvalid); else passed++;
        @(negedge clock);
        total++; if (io_awvalid !== 1'b1 || io_wvalid !== 1'b1 || io_arvalid !== 1'b0) $display("FAIL same_write_first: got aw %b w %b ar %b want 110", io_awvalid, io_wvalid, io_arvalid); else passed++;
        total++; if (lsu_awready !== 1'b1 || lsu_wready !== 1'b1 || io_wstrb !== 4'h3) $display("FAIL same_ready: got %b %b strb %h want 1 1 3", lsu_awready, lsu_wready, io_wstrb); else passed++;
        @(negedge clock);
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; io_awready = 1'b0; io_wready = 1'b0;
        #1;
        total++; if (io_awvalid !== 1'b0 || io_wvalid !== 1'b0) $display("FAIL same_no_dup: got aw %b w %b want 00", io_awvalid, io_wvalid); else passed++;
        total++; if (aw_hs_cnt - aw0 != 1 || w_hs_cnt - w0 != 1) $display("FAIL same_hs_count: got aw %0d w %0d want 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0); else passed++;
        io_bvalid = 1'b1; io_bresp = 2'b10; lsu_bready = 1'b1;
        #1;
        total++; if (lsu_bvalid !== 1'b1 || lsu_bresp !== 2'b10) $display("FAIL same_b_route: got %b %b want 1 10", lsu_bvalid, lsu_bresp); else passed++;
        @(negedge clock);
        io_bvalid = 1'b0; lsu_bready = 1'b0;
        #1;
        total++; if (io_arvalid !== 1'b0) $display("FAIL same_bubble: got %b want 0", io_arvalid); else passed++;
        io_arready = 1'b1;
        @(negedge clock);
        total++; if (io_arvalid !== 1'b1 || io_arid !== 4'd1 || io_araddr !== 32'h0F00_0004) $display("FAIL same_read_after: got %b id %0d %h", io_arvalid, io_arid, io_araddr); else passed++;
        lsu_arvalid = 1'b0;
        @(negedge clock);
        io_arready = 1'b0; io_rvalid = 1'b1; io_rlast = 1'b1; io_rdata = 32'hCAFE_F00D; io_rresp = 2'b00; lsu_rready = 1'b1;
        #1;
        total++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'hCAFE_F00D || lsu_rresp !== 2'b00 || ifu_rvalid !== 1'b0) $display("FAIL same_lsu_r: got %b %h %b ifu %b", lsu_rvalid, lsu_rdata, lsu_rresp, ifu_rvalid); else passed++;
        @(negedge clock);
        io_rvalid = 1'b0; io_rlast = 1'b0; lsu_rready = 1'b0;
    endtask

    task automatic test_timeout();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0040; io_arready = 1'b1; ifu_rready = 1'b1;
        @(negedge clock);
        ifu_arvalid = 1'b0;
        @(negedge clock);
        io_arready = 1'b0;
        total++; if (err_timeout !== 1'b0) $display("FAIL to_start: got %b want 0", err_timeout); else passed++;
        repeat (TIMEOUT - 1) @(negedge clock);
        total++; if (err_timeout !== 1'b0) $display("FAIL to_early: got %b want 0", err_timeout); else passed++;
        @(negedge clock);
        total++; if (err_timeout !== 1'b1) $display("FAIL to_exact: got %b want 1", err_timeout); else passed++;
        @(negedge clock);
        io_rvalid = 1'b1; io_rlast = 1'b1; io_rdata = 32'h0000_0013; io_rresp = 2'b00;
        #1;
        total++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0013) $display("FAIL to_late_r: got %b %h want 1 00000013", ifu_rvalid, ifu_rdata); else passed++;
        @(negedge clock);
        io_rvalid = 1'b0; io_rlast = 1'b0; ifu_rready = 1'b0;
        #1;
        total++; if (err_timeout !== 1'b1 || io_rready !== 1'b0) $display("FAIL to_sticky: got err %b rready %b want 1 0", err_timeout, io_rready); else passed++;
    endtask

    task automatic test_async_reset();
        io_awready = 1'b0; io_wready = 1'b0;
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h0F00_0010; lsu_wvalid = 1'b1;
        lsu_wdata = 32'h0BAD_F00D; lsu_wstrb = 4'hF;
        @(negedge clock);
        total++; if (io_awvalid !== 1'b1 || io_wvalid !== 1'b1) $display("FAIL ar_pre_valids: got %b%b want 11", io_awvalid, io_wvalid); else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++; if (io_awvalid !== 1'b0 || io_wvalid !== 1'b0 || io_arvalid !== 1'b0) $display("FAIL ar_async_valids: got aw %b w %b ar %b want 000", io_awvalid, io_wvalid, io_arvalid); else passed++;
        total++; if (err_timeout !== 1'b0) $display("FAIL ar_async_err: got %b want 0", err_timeout); else passed++;
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h4000_0000;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h5000_0000;
        @(negedge clock);
        total++; if (io_arvalid !== 1'b1 || io_arid !== 4'd0) $display("FAIL ar_grant_reset: got %b id %0d want 1 0", io_arvalid, io_arid); else passed++;
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_rready = 1'b0;
        lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_arsize = '0; lsu_rready = 1'b0;
        lsu_awvalid = 1'b0; lsu_awaddr = '0; lsu_awsize = 3'b010;
        lsu_wvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_bready = 1'b0;
        io_arready = 1'b0; io_rvalid = 1'b0; io_rdata = '0; io_rresp = '0; io_rlast = 1'b0; io_rid = 4'd7;
        io_awready = 1'b0; io_wready = 1'b0; io_bvalid = 1'b0; io_bresp = '0; io_bid = 4'd7;

        test_reset();
        test_tie_alternation();
        test_ifu_read();
        test_write_split();
        test_write_same_cycle();
        test_timeout();
        test_async_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
